xy_eval_arbiter: RTL and testbench

- Shares one pipelined evaluator of the composite x/y function, z = x | ~y, among NREQ requesters.
- Each requester offers an {x,y} operand pair on a valid/ready handshake. A round-robin arbiter grants at most one pair per cycle.
- The result passes through a fixed-latency pipeline into a credit-protected response FIFO, tagged with the requester index.
- The block sits in front of the x/y function units and is the only path by which clients obtain z.

---
 rtl/xy_eval_arbiter.sv | 122 ++++++++++++
 tb/tb_xy_eval_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xy_eval_arbiter.sv
// Round-robin arbiter in front of a shared z = x | ~y evaluator pipeline.
// Results are tagged with the requester index and queued in a credit-protected response FIFO.
module xy_eval_arbiter #(
  parameter int NREQ      = 4,
  parameter int LAT       = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_x,
  input  logic [NREQ-1:0]         req_y,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic                    rsp_z,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  input  logic                    rsp_ready,
  output logic                    busy,
  output logic [15:0]             grant_count
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] rr_ptr;
  logic [LAT-1:0] stage_valid;
  logic [LAT-1:0] stage_z;
  logic [IDW-1:0] stage_id [LAT];

  logic           mem_z  [RSP_DEPTH];
  logic [IDW-1:0] mem_id [RSP_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_count;
  logic           hold_z;
  logic [IDW-1:0] hold_id;

  logic [CW-1:0]  inflight;
  logic           credit_ok;
  logic           grant;
  logic [IDW-1:0] grant_idx;
  logic           push;
  logic           pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(stage_valid[i]);
  end

  // Same-cycle pop is deliberately ignored so the FIFO can never overflow.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(RSP_DEPTH);

  // Scan from farthest to nearest so the nearest valid requester after rr_ptr wins.
  always_comb begin
    logic [IDW-1:0] cand;
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (credit_ok) begin
      for (int k = NREQ; k >= 1; k--) begin
        cand = IDW'((int'(rr_ptr) + k) % NREQ);
        if (req_valid[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  assign push      = stage_valid[LAT-1];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = (|stage_valid) | rsp_valid;
  assign rsp_z     = rsp_valid ? mem_z[rd_ptr]  : hold_z;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : hold_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= IDW'(NREQ - 1);
      stage_valid <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      hold_z      <= 1'b0;
      hold_id     <= '0;
      grant_count <= '0;
    end else begin
      stage_valid[0] <= grant;
      for (int i = 1; i < LAT; i++) stage_valid[i] <= stage_valid[i-1];
      if (grant) begin
        rr_ptr      <= grant_idx;
        grant_count <= grant_count + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        hold_z  <= mem_z[rd_ptr];
        hold_id <= mem_id[rd_ptr];
      end
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Data path carries no reset; validity is tracked by stage_valid and fifo_count.
  always_ff @(posedge clk) begin
    stage_z[0]  <= req_x[grant_idx] | ~req_y[grant_idx];
    stage_id[0] <= grant_idx;
    for (int i = 1; i < LAT; i++) begin
      stage_z[i]  <= stage_z[i-1];
      stage_id[i] <= stage_id[i-1];
    end
    if (push) begin
      mem_z[wr_ptr]  <= stage_z[LAT-1];
      mem_id[wr_ptr] <= stage_id[LAT-1];
    end
  end

endmodule

// File: tb/tb_xy_eval_arbiter.sv
// Bench for xy_eval_arbiter: fixed vectors, directed corner sequences and random traffic,
// all checked against a queue-based model of outstanding requests.
module tb_xy_eval_arbiter;
  localparam int NREQ = 4, LAT = 2, RSP_DEPTH = 4, IDW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_x = '0, req_y = '0, req_ready;
  logic            rsp_valid, rsp_z, busy;
  logic            rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     grant_count;

  xy_eval_arbiter #(.NREQ(NREQ), .LAT(LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit z; int id; int t; } item_t;
  typedef struct {
    logic [3:0] v, x, y;
    logic       rr;
    logic [3:0] e_rdy;
    logic       e_rv, e_z;
    logic [1:0] e_id;
    logic [15:0] e_gc;
  } vec_t;

  item_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int m_rr = NREQ - 1, m_gcnt = 0, m_lid = 0, last_grant = -1;
  bit m_lz = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept if fewer than RSP_DEPTH results are outstanding; first valid after the last winner.
  function automatic int exp_grant();
    if (q.size() >= RSP_DEPTH) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i = (m_rr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    bit ev;
    item_t it;
    #1;
    g = exp_grant();
    ev = (q.size() > 0) && (q[0].t <= cyc);
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_z", rsp_z, ev ? q[0].z : m_lz);
    chk("rsp_id", rsp_id, ev ? q[0].id : m_lid);
    chk("busy", busy, q.size() > 0);
    chk("grant_count", grant_count, m_gcnt % 65536);
    last_grant = g;
    if (ev && rsp_ready) begin
      m_lz = q[0].z;
      m_lid = q[0].id;
      void'(q.pop_front());
    end
    if (g >= 0) begin
      it.z = (req_x[g] == 1'b1) || (req_y[g] == 1'b0);
      it.id = g;
      it.t = cyc + LAT + 1;
      q.push_back(it);
      m_rr = g;
      m_gcnt++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    cyc++;
    q.delete();
    m_rr = NREQ - 1;
    m_gcnt = 0;
    m_lz = 1'b0;
    m_lid = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl[9];
  int hist[16];
  int ng, acc, bound;

  initial begin
    tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 16'd0};
    tbl[1] = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 16'd1};
    tbl[2] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 16'd2};
    tbl[3] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd0, 16'd3};
    tbl[4] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 16'd4};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 16'd5};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 16'd5};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 16'd5};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 16'd5};

    @(negedge clk);
    do_reset();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_z", rsp_z, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_grant_count", grant_count, 0);

    // Single request followed by the requester-2 truth table.
    for (int r = 0; r < 9; r++) begin
      req_valid = tbl[r].v; req_x = tbl[r].x; req_y = tbl[r].y; rsp_ready = tbl[r].rr;
      #1;
      chk("tbl_ready", req_ready, tbl[r].e_rdy);
      chk("tbl_rsp_valid", rsp_valid, tbl[r].e_rv);
      chk("tbl_rsp_z", rsp_z, tbl[r].e_z);
      chk("tbl_rsp_id", rsp_id, tbl[r].e_id);
      chk("tbl_grant_count", grant_count, tbl[r].e_gc);
      step();
    end

    // Fairness with everyone requesting.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      req_x = 4'($urandom); req_y = 4'($urandom);
      step();
      hist[k] = last_grant;
      chk("rr_order", last_grant, k % 4);
      if (k >= 3)
        chk("rr_window", (hist[k] != hist[k-1]) && (hist[k] != hist[k-2]) && (hist[k] != hist[k-3]), 1);
    end

    // Backpressure: credit must stop grants at RSP_DEPTH outstanding.
    do_reset();
    req_valid = 4'b1111;
    ng = 0;
    for (int k = 0; k < 8; k++) begin
      req_x = 4'($urandom); req_y = 4'($urandom);
      step();
      if (last_grant >= 0) ng++;
    end
    chk("bp_grants", ng, 4);
    #1;
    chk("bp_ready_blocked", req_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    ng = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (last_grant >= 0) ng++;
    end
    chk("bp_regrant", ng, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("bp_drained", busy, 0);

    // Reset with two results queued and two in the pipeline.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) step();
    do_reset();
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_grant_count", grant_count, 0);
    req_valid = 4'b1001;
    #1;
    chk("rst_mid_prio", req_ready, 4'b0001);
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else begin
        req_valid = 4'($urandom); req_x = 4'($urandom); req_y = 4'($urandom);
        rsp_ready = 1'($urandom_range(0, 3) != 0);
        step();
      end
    end

    // grant_count wrap after 65536 accepts.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    acc = 0;
    bound = 0;
    while (acc < 65536 && bound < 70000) begin
      req_x = 4'($urandom); req_y = 4'($urandom);
      step();
      if (last_grant >= 0) acc++;
      bound++;
    end
    chk("wrap_accepts", acc, 65536);
    req_valid = '0;
    #1;
    chk("wrap_zero", grant_count, 0);
    req_valid = 4'b0010;
    for (int k = 0; k < 8; k++) step();
    req_valid = '0;
    for (int k = 0; k < 6; k++) step();
    chk("wrap_after", grant_count, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
